// File: rtl/mux_pkg.sv
// mux_pkg: shared mode constants and width helper for mux_arb_reg
package mux_pkg;
  localparam logic MODE_SEL = 1'b0;
  localparam logic MODE_RR = 1'b1;
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/rr_pick.sv
// rr_pick: rotating-priority pick of the first set req bit starting at ptr
module rr_pick #(
  parameter int N_CH = 4,
  parameter int SEL_W = 2
) (
  input  logic [N_CH-1:0]  req,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] gnt_idx,
  output logic             gnt_vld
);
  logic [SEL_W-1:0] idx;
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    idx = '0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      idx = SEL_W'((int'(ptr) + k) % N_CH);
      if (req[idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = idx;
      end
    end
  end
endmodule

// File: rtl/mux_arb_reg.sv
// mux_arb_reg: N-channel registered mux, select or round-robin grant, valid/ready both sides; MUX_ARB_PARITY_EN adds out_par
module mux_arb_reg
  import mux_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int DATA_W = 8,
  parameter int SEL_W = clog2_min1(N_CH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_CH-1:0]        in_valid,
  input  logic [N_CH*DATA_W-1:0] in_data,
  output logic [N_CH-1:0]        in_ready,
  input  logic                   mode,
  input  logic [SEL_W-1:0]       sel,
  output logic                   out_valid,
  output logic [DATA_W-1:0]      out_data,
  output logic [SEL_W-1:0]       out_ch,
  input  logic                   out_ready
`ifdef MUX_ARB_PARITY_EN
  ,
  output logic                   out_par
`endif
);
  localparam int NP = 1 << SEL_W;
  logic [NP-1:0] vmask;
  logic [DATA_W-1:0] ch_data [NP];
  logic [SEL_W-1:0] rr_ptr, rr_idx, gnt;
  logic rr_vld, gnt_vld, load_en, take;
  rr_pick #(.N_CH(N_CH), .SEL_W(SEL_W)) u_pick (
    .req(in_valid),
    .ptr(rr_ptr),
    .gnt_idx(rr_idx),
    .gnt_vld(rr_vld)
  );
  for (genvar i = 0; i < NP; i++) begin : g_ch
    if (i < N_CH) begin : g_v
      assign ch_data[i] = in_data[i*DATA_W +: DATA_W];
    end else begin : g_z
      assign ch_data[i] = '0;
    end
  end
  assign vmask = NP'(in_valid);
  assign gnt = (mode == MODE_RR) ? rr_idx : sel;
  assign gnt_vld = (mode == MODE_RR) ? rr_vld : vmask[sel];
  assign load_en = !out_valid || out_ready;
  assign take = rst_n && load_en && gnt_vld;
  assign in_ready = take ? N_CH'(1) << gnt : '0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data <= '0;
      out_ch <= '0;
      rr_ptr <= '0;
    end else if (take) begin
      out_valid <= 1'b1;
      out_data <= ch_data[gnt];
      out_ch <= gnt;
      if (mode == MODE_RR) rr_ptr <= (gnt == SEL_W'(N_CH - 1)) ? '0 : gnt + 1'b1;
    end else if (load_en) begin
      out_valid <= 1'b0;
    end
  end
`ifdef MUX_ARB_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) out_par <= 1'b0;
    else if (take) out_par <= ^ch_data[gnt];
  end
`endif
endmodule

// File: tb/tb_mux_arb_reg.sv
// tb_mux_arb_reg: randomized and directed checks of mux_arb_reg against a behavioural model
module tb_mux_arb_reg;
  localparam int N = 4;
  localparam int W = 8;
  localparam int SW = 2;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [N-1:0] in_valid = '0;
  logic [N*W-1:0] in_data = '0;
  logic [N-1:0] in_ready;
  logic mode = 1'b0;
  logic [SW-1:0] sel = '0;
  logic out_valid;
  logic [W-1:0] out_data;
  logic [SW-1:0] out_ch;
  logic out_ready = 1'b1;
`ifdef MUX_ARB_PARITY_EN
  logic out_par;
`endif
  int nchk = 0;
  int nfail = 0;
  bit mv;
  logic [W-1:0] md;
  int mch, mptr;
  always #5 clk = ~clk;
  mux_arb_reg #(.N_CH(N), .DATA_W(W)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_data(in_data),
    .in_ready(in_ready),
    .mode(mode),
    .sel(sel),
    .out_valid(out_valid),
    .out_data(out_data),
    .out_ch(out_ch),
    .out_ready(out_ready)
`ifdef MUX_ARB_PARITY_EN
    ,
    .out_par(out_par)
`endif
  );
  function automatic int mgrant();
    if (!mode) return in_valid[sel] ? int'(sel) : -1;
    for (int k = 0; k < N; k++)
      if (in_valid[(mptr + k) % N]) return (mptr + k) % N;
    return -1;
  endfunction
  function automatic logic [N-1:0] mready();
    logic [N-1:0] r = '0;
    int g = mgrant();
    if (g >= 0 && (!mv || out_ready)) r[g] = 1'b1;
    return r;
  endfunction
  function automatic logic [W-1:0] chd(int c);
    return in_data[c*W +: W];
  endfunction
  task automatic model_reset();
    mv = 0; md = '0; mch = 0; mptr = 0;
  endtask
  task automatic step();
    int g = mgrant();
    bit ld = !mv || out_ready;
    logic [W-1:0] d = (g >= 0) ? chd(g) : '0;
    @(posedge clk);
    if (ld) begin
      if (g >= 0) begin
        mv = 1; md = d; mch = g;
        if (mode) mptr = (g + 1) % N;
      end else mv = 0;
    end
    #1;
  endtask
  task automatic rand_data();
    for (int i = 0; i < N; i++) in_data[i*W +: W] = W'($urandom);
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask
  task automatic test_reset();
    in_valid = '1; mode = 1'b1; out_ready = 1'b1;
    rand_data();
    repeat (2) @(posedge clk);
    #1;
    nchk++; if (out_valid !== 1'b0) begin nfail++; $display("FAIL reset_valid got %b want 0", out_valid); end
    nchk++; if (out_data !== '0) begin nfail++; $display("FAIL reset_data got %h want 00", out_data); end
    nchk++; if (out_ch !== '0) begin nfail++; $display("FAIL reset_ch got %0d want 0", out_ch); end
    nchk++; if (in_ready !== '0) begin nfail++; $display("FAIL reset_ready got %b want 0000", in_ready); end
    rst_n = 1'b1;
    model_reset();
    #2;
    nchk++; if (in_ready !== 4'b0001) begin nfail++; $display("FAIL release_ready got %b want 0001", in_ready); end
    step();
    nchk++; if ({out_valid, out_ch, out_data} !== {1'b1, 2'd0, chd(0)}) begin nfail++; $display("FAIL release_xfer got %b/%0d/%h want 1/0/%h", out_valid, out_ch, out_data, chd(0)); end
  endtask
  task automatic test_reset_mid();
    do_reset();
    mode = 1'b0; sel = 2'd3; in_valid = '1; out_ready = 1'b0; rand_data();
    step();
    rst_n = 1'b0;
    #1;
    nchk++; if ({out_valid, out_data} !== {1'b0, 8'h00}) begin nfail++; $display("FAIL mid_reset got %b/%h want 0/00", out_valid, out_data); end
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask
  task automatic test_sel();
    do_reset();
    mode = 1'b0; sel = 2'd2; in_valid = '1; out_ready = 1'b1; rand_data();
    in_data[2*W +: W] = 8'hA5;
    #2;
    nchk++; if (in_ready !== 4'b0100) begin nfail++; $display("FAIL sel_ready got %b want 0100", in_ready); end
    step();
    nchk++; if ({out_valid, out_ch, out_data} !== {1'b1, 2'd2, 8'hA5}) begin nfail++; $display("FAIL sel_out got %b/%0d/%h want 1/2/a5", out_valid, out_ch, out_data); end
  endtask
  task automatic test_rr_order();
    do_reset();
    mode = 1'b1; in_valid = '1; out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      rand_data();
      #2;
      nchk++; if (in_ready !== 4'(1 << (k % 4))) begin nfail++; $display("FAIL rr_ready[%0d] got %b want %b", k, in_ready, 4'(1 << (k % 4))); end
      step();
      nchk++; if ({out_valid, out_ch, out_data} !== {1'b1, 2'(k % 4), md}) begin nfail++; $display("FAIL rr_out[%0d] got %b/%0d/%h want 1/%0d/%h", k, out_valid, out_ch, out_data, k % 4, md); end
    end
  endtask
  task automatic test_backpressure();
    logic [W-1:0] held;
    do_reset();
    mode = 1'b0; sel = 2'd1; in_valid = '1; out_ready = 1'b1; rand_data();
    held = chd(1);
    step();
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      rand_data();
      #2;
      nchk++; if (in_ready !== '0) begin nfail++; $display("FAIL bp_ready[%0d] got %b want 0000", k, in_ready); end
      step();
      nchk++; if ({out_valid, out_data} !== {1'b1, held}) begin nfail++; $display("FAIL bp_hold[%0d] got %b/%h want 1/%h", k, out_valid, out_data, held); end
    end
    out_ready = 1'b1; sel = 2'd3;
    #2;
    nchk++; if (in_ready !== 4'b1000) begin nfail++; $display("FAIL bp_drain_ready got %b want 1000", in_ready); end
    step();
    nchk++; if ({out_valid, out_ch, out_data} !== {1'b1, 2'd3, chd(3)}) begin nfail++; $display("FAIL bp_drain_out got %b/%0d/%h want 1/3/%h", out_valid, out_ch, out_data, chd(3)); end
  endtask
  task automatic test_rr_skip();
    do_reset();
    mode = 1'b1; in_valid = '1; out_ready = 1'b1; rand_data();
    step();
    step();
    in_valid = 4'b1010;
    #2;
    nchk++; if (in_ready !== 4'b1000) begin nfail++; $display("FAIL skip_ready_a got %b want 1000", in_ready); end
    step();
    nchk++; if (out_ch !== 2'd3) begin nfail++; $display("FAIL skip_ch_a got %0d want 3", out_ch); end
    #2;
    nchk++; if (in_ready !== 4'b0010) begin nfail++; $display("FAIL skip_ready_b got %b want 0010", in_ready); end
    step();
    nchk++; if (out_ch !== 2'd1) begin nfail++; $display("FAIL skip_ch_b got %0d want 1", out_ch); end
  endtask
  task automatic test_parity();
`ifdef MUX_ARB_PARITY_EN
    do_reset();
    mode = 1'b0; sel = 2'd0; in_valid = '1; out_ready = 1'b1;
    in_data[0 +: W] = 8'hA5;
    step();
    nchk++; if (out_par !== 1'b0) begin nfail++; $display("FAIL par_a5 got %b want 0", out_par); end
    in_data[0 +: W] = 8'h07;
    step();
    nchk++; if (out_par !== 1'b1) begin nfail++; $display("FAIL par_07 got %b want 1", out_par); end
`else
    #0;
`endif
  endtask
  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      in_valid = N'($urandom);
      rand_data();
      sel = SW'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0) mode = ~mode;
      #2;
      nchk++; if (in_ready !== mready()) begin nfail++; $display("FAIL rand_ready[%0d] got %b want %b", c, in_ready, mready()); end
      step();
      nchk++; if ({out_valid, out_ch, out_data} !== {mv, 2'(mch), md}) begin nfail++; $display("FAIL rand_out[%0d] got %b/%0d/%h want %b/%0d/%h", c, out_valid, out_ch, out_data, mv, mch, md); end
`ifdef MUX_ARB_PARITY_EN
      nchk++; if (out_par !== ^md) begin nfail++; $display("FAIL rand_par[%0d] got %b want %b", c, out_par, ^md); end
`endif
    end
  endtask
  initial begin
    model_reset();
    @(posedge clk);
    #1;
    test_reset();
    test_reset_mid();
    test_sel();
    test_rr_order();
    test_backpressure();
    test_rr_skip();
    test_parity();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule
